// File: rtl/gp_wr_arbiter_pkg.sv
// Shared sizes, defaults and the queued-write entry type for the GP
// register-file write-port arbiter.
package gp_wr_arbiter_pkg;

  localparam int SIZE_TGT_GP      = 5;
  localparam int SIZE_DATA        = 32;
  localparam int NUM_GP           = 1 << SIZE_TGT_GP;
  localparam int GP_FIFO_DEPTH    = 2;
  localparam int GP_MAX_WAIT      = 4;
  localparam int SIZE_GP_FIFO_CNT = $clog2(GP_FIFO_DEPTH) + 1;

  // One queued MC write; kill marks it as superseded by a younger WB write.
  typedef struct packed {
    logic [SIZE_TGT_GP-1:0] addr;
    logic [SIZE_DATA-1:0]   data;
    logic                   kill;
  } gp_wr_entry_t;

  // One-hot register mask for a single target address.
  function automatic logic [NUM_GP-1:0] gp_onehot(input logic [SIZE_TGT_GP-1:0] a);
    return NUM_GP'(1) << a;
  endfunction

endpackage

// File: rtl/gp_wr_fifo.sv
// Small FIFO holding long-latency (MC) register writes until the write port
// is idle. Entries targeting a register the pipeline writes are killed so an
// older queued value never overwrites a younger pipeline result.
module gp_wr_fifo
  import gp_wr_arbiter_pkg::*;
#(
  parameter int  DEPTH = GP_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic                   iw_enq,
  input  logic [SIZE_TGT_GP-1:0] iw_enq_addr,
  input  logic [SIZE_DATA-1:0]   iw_enq_data,
  input  logic                   iw_deq,
  input  logic                   iw_kill_en,
  input  logic [SIZE_TGT_GP-1:0] iw_kill_addr,
  output logic [CW-1:0]          ow_count,
  output logic [SIZE_TGT_GP-1:0] ow_head_addr,
  output logic [SIZE_DATA-1:0]   ow_head_data,
  output logic                   ow_head_kill,
  output logic [NUM_GP-1:0]      ow_pending_mask
);

  gp_wr_entry_t     mem_q [DEPTH];
  gp_wr_entry_t     mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             enq_s, deq_s;
  logic [NUM_GP-1:0] mask_s;

  // Next-state: kill matching live entries, then retire the head, then append.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enq_s    = iw_enq && (count_q < CW'(DEPTH));
    deq_s    = iw_deq && (count_q != '0);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !mem_q[i].kill && iw_kill_en && (mem_q[i].addr == iw_kill_addr)) begin
        mem_d[i].kill = 1'b1;
      end else begin
        mem_d[i].kill = mem_q[i].kill;
      end
    end
    if (deq_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // A same-cycle enqueue is younger than the WB write, so it lands unkilled.
    if (enq_s) begin
      mem_d[wr_ptr_q].addr = iw_enq_addr;
      mem_d[wr_ptr_q].data = iw_enq_data;
      mem_d[wr_ptr_q].kill = 1'b0;
      valid_d[wr_ptr_q]    = 1'b1;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; reset discards every queued write.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Pending mask: registers still owed a live queued write, for decode interlock.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !mem_q[i].kill) begin
        mask_s = mask_s | gp_onehot(mem_q[i].addr);
      end else begin
        mask_s = mask_s;
      end
    end
  end

  assign ow_count        = count_q;
  assign ow_head_addr    = mem_q[rd_ptr_q].addr;
  assign ow_head_data    = mem_q[rd_ptr_q].data;
  assign ow_head_kill    = mem_q[rd_ptr_q].kill;
  assign ow_pending_mask = mask_s;

endmodule

// File: rtl/gp_wr_arbiter.sv
// Arbitrates the single GP register-file write port between pipeline
// writeback (always wins) and queued MC writes drained into idle cycles.
// A starvation counter asks upstream for a writeback bubble when the queue
// head has waited too long.
module gp_wr_arbiter
  import gp_wr_arbiter_pkg::*;
#(
  parameter int  DEPTH    = GP_FIFO_DEPTH,
  parameter int  MAX_WAIT = GP_MAX_WAIT,
  localparam int CW       = $clog2(DEPTH) + 1,
  localparam int WW       = $clog2(MAX_WAIT + 1)
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic                   iw_wb_we,
  input  logic [SIZE_TGT_GP-1:0] iw_wb_addr,
  input  logic [SIZE_DATA-1:0]   iw_wb_data,
  input  logic                   iw_mc_valid,
  output logic                   ow_mc_ready,
  input  logic [SIZE_TGT_GP-1:0] iw_mc_addr,
  input  logic [SIZE_DATA-1:0]   iw_mc_data,
  output logic                   ow_gp_write_enable,
  output logic [SIZE_TGT_GP-1:0] ow_gp_write_addr,
  output logic [SIZE_DATA-1:0]   ow_gp_write_data,
  output logic                   ow_wb_stall,
  output logic [NUM_GP-1:0]      ow_pending_mask,
  output logic [CW-1:0]          ow_fifo_count
);

  logic [CW-1:0]          count_s;
  logic [SIZE_TGT_GP-1:0] head_addr_s;
  logic [SIZE_DATA-1:0]   head_data_s;
  logic                   head_kill_s;
  logic                   ready_s, enq_s, deq_s;
  logic                   we_s;
  logic [SIZE_TGT_GP-1:0] addr_s;
  logic [SIZE_DATA-1:0]   data_s;
  logic [WW-1:0]          wait_q, wait_d;
  logic                   stall_q;

  gp_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .iw_clk          (iw_clk),
    .iw_rst          (iw_rst),
    .iw_enq          (enq_s),
    .iw_enq_addr     (iw_mc_addr),
    .iw_enq_data     (iw_mc_data),
    .iw_deq          (deq_s),
    .iw_kill_en      (iw_wb_we),
    .iw_kill_addr    (iw_wb_addr),
    .ow_count        (count_s),
    .ow_head_addr    (head_addr_s),
    .ow_head_data    (head_data_s),
    .ow_head_kill    (head_kill_s),
    .ow_pending_mask (ow_pending_mask)
  );

  // Port mux: WB first, else the queue head (silently dropped if killed).
  always_comb begin
    we_s    = 1'b0;
    addr_s  = '0;
    data_s  = '0;
    deq_s   = 1'b0;
    ready_s = 1'b0;
    if (iw_rst) begin
      we_s    = 1'b0;
      ready_s = 1'b0;
    end else if (iw_wb_we) begin
      we_s    = 1'b1;
      addr_s  = iw_wb_addr;
      data_s  = iw_wb_data;
      ready_s = (count_s < CW'(DEPTH));
    end else if (count_s != '0) begin
      we_s    = !head_kill_s;
      addr_s  = head_addr_s;
      data_s  = head_data_s;
      deq_s   = 1'b1;
      ready_s = (count_s < CW'(DEPTH));
    end else begin
      ready_s = 1'b1;
    end
    enq_s = iw_mc_valid && ready_s;
  end

  // Starvation counter: ages the head while it is blocked, saturating.
  always_comb begin
    wait_d = wait_q;
    if ((count_s == '0) || deq_s) begin
      wait_d = '0;
    end else if (wait_q == WW'(MAX_WAIT)) begin
      wait_d = wait_q;
    end else begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Wait counter and registered stall request.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= (wait_d == WW'(MAX_WAIT));
    end
  end

  assign ow_mc_ready        = ready_s;
  assign ow_gp_write_enable = we_s;
  assign ow_gp_write_addr   = addr_s;
  assign ow_gp_write_data   = data_s;
  assign ow_wb_stall        = stall_q;
  assign ow_fifo_count      = count_s;

endmodule

// File: tb/tb_gp_wr_arbiter.sv
// Self-checking bench for gp_wr_arbiter: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_gp_wr_arbiter;
  import gp_wr_arbiter_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic                   iw_clk = 1'b0;
  logic                   iw_rst = 1'b1;
  logic                   iw_wb_we = 1'b0;
  logic [SIZE_TGT_GP-1:0] iw_wb_addr = '0;
  logic [SIZE_DATA-1:0]   iw_wb_data = '0;
  logic                   iw_mc_valid = 1'b0;
  logic [SIZE_TGT_GP-1:0] iw_mc_addr = '0;
  logic [SIZE_DATA-1:0]   iw_mc_data = '0;
  logic                   ow_mc_ready;
  logic                   ow_gp_write_enable;
  logic [SIZE_TGT_GP-1:0] ow_gp_write_addr;
  logic [SIZE_DATA-1:0]   ow_gp_write_data;
  logic                   ow_wb_stall;
  logic [NUM_GP-1:0]      ow_pending_mask;
  logic [CW-1:0]          ow_fifo_count;

  gp_wr_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .iw_clk             (iw_clk),
    .iw_rst             (iw_rst),
    .iw_wb_we           (iw_wb_we),
    .iw_wb_addr         (iw_wb_addr),
    .iw_wb_data         (iw_wb_data),
    .iw_mc_valid        (iw_mc_valid),
    .ow_mc_ready        (ow_mc_ready),
    .iw_mc_addr         (iw_mc_addr),
    .iw_mc_data         (iw_mc_data),
    .ow_gp_write_enable (ow_gp_write_enable),
    .ow_gp_write_addr   (ow_gp_write_addr),
    .ow_gp_write_data   (ow_gp_write_data),
    .ow_wb_stall        (ow_wb_stall),
    .ow_pending_mask    (ow_pending_mask),
    .ow_fifo_count      (ow_fifo_count)
  );

  always #5 iw_clk = ~iw_clk;

  int n_pass  = 0;
  int n_total = 0;
  bit aaaa_written = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: queue of pending MC writes and head blocked-age.
  typedef struct {
    logic [SIZE_TGT_GP-1:0] a;
    logic [SIZE_DATA-1:0]   d;
    bit                     k;
  } m_ent_t;
  m_ent_t mq[$];
  int     mw = 0;

  always @(posedge iw_clk or posedge iw_rst) begin
    bit     deq, acc;
    m_ent_t e;
    if (iw_rst) begin
      mq.delete();
      mw = 0;
    end else begin
      deq = !iw_wb_we && (mq.size() > 0);
      acc = iw_mc_valid && (mq.size() < DEPTH);
      if (mq.size() == 0 || deq) mw = 0;
      else if (mw < MAX_WAIT) mw++;
      if (iw_wb_we) foreach (mq[i]) if (mq[i].a == iw_wb_addr) mq[i].k = 1'b1;
      if (deq) void'(mq.pop_front());
      if (acc) begin
        e.a = iw_mc_addr; e.d = iw_mc_data; e.k = 1'b0;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle compare against the model, mid-cycle.
  always @(negedge iw_clk) begin
    logic                   en;
    logic [SIZE_TGT_GP-1:0] ad;
    logic [SIZE_DATA-1:0]   da;
    logic [NUM_GP-1:0]      m;
    if (iw_rst) begin
      check("rst_en", ow_gp_write_enable, 1'b0);
      check("rst_ready", ow_mc_ready, 1'b0);
      check("rst_count", ow_fifo_count, 0);
      check("rst_mask", ow_pending_mask, 0);
      check("rst_stall", ow_wb_stall, 1'b0);
    end else begin
      m = '0;
      foreach (mq[i]) if (!mq[i].k) m[mq[i].a] = 1'b1;
      if (iw_wb_we) begin en = 1'b1; ad = iw_wb_addr; da = iw_wb_data; end
      else if (mq.size() > 0) begin en = !mq[0].k; ad = mq[0].a; da = mq[0].d; end
      else begin en = 1'b0; ad = '0; da = '0; end
      check("m_en", ow_gp_write_enable, en);
      check("m_addr", ow_gp_write_addr, ad);
      check("m_data", ow_gp_write_data, da);
      check("m_ready", ow_mc_ready, mq.size() < DEPTH);
      check("m_count", ow_fifo_count, mq.size());
      check("m_mask", ow_pending_mask, m);
      check("m_stall", ow_wb_stall, mw == MAX_WAIT);
      if (ow_gp_write_enable && ow_gp_write_addr == 5'd5 && ow_gp_write_data == 32'hAAAA)
        aaaa_written = 1'b1;
    end
  end

  task automatic step();
    @(posedge iw_clk); #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_ready", ow_mc_ready, 1'b0);
    check("reset_count", ow_fifo_count, 0);
    step(); step();
    iw_rst = 1'b0;
    #1;
    check("post_reset_ready", ow_mc_ready, 1'b1);
    check("post_reset_en", ow_gp_write_enable, 1'b0);

    // Idle pipeline: MC write lands on the port the next cycle
    iw_mc_valid = 1'b1; iw_mc_addr = 5'd3; iw_mc_data = 32'h1234;
    #1; check("t1_ready", ow_mc_ready, 1'b1);
    check("t1_no_bypass", ow_gp_write_enable, 1'b0);
    step();
    iw_mc_valid = 1'b0;
    #1;
    check("t1_en", ow_gp_write_enable, 1'b1);
    check("t1_addr", ow_gp_write_addr, 5'd3);
    check("t1_data", ow_gp_write_data, 32'h1234);
    check("t1_count1", ow_fifo_count, 1);
    step(); #1;
    check("t1_count0", ow_fifo_count, 0);

    // Back-to-back WB for 6 cycles while MC queues two entries
    iw_wb_we = 1'b1; iw_wb_addr = 5'd1; iw_wb_data = 32'h100;
    iw_mc_valid = 1'b1; iw_mc_addr = 5'd10; iw_mc_data = 32'hA0;
    #1; check("t2_wb_en", ow_gp_write_enable, 1'b1);
    step();
    iw_wb_addr = 5'd2; iw_wb_data = 32'h200; iw_mc_addr = 5'd11; iw_mc_data = 32'hB0;
    #1; check("t2_ready_c1", ow_mc_ready, 1'b1);
    check("t2_count_c1", ow_fifo_count, 1);
    step();
    iw_mc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iw_wb_addr = 5'(3 + k); iw_wb_data = 32'(16'h300 + k);
      #1;
      check("t2_ready_full", ow_mc_ready, 1'b0);
      check("t2_count_full", ow_fifo_count, 2);
      check("t2_wb_addr", ow_gp_write_addr, 5'(3 + k));
      check("t2_stall", ow_wb_stall, k == 3);
      step();
    end
    iw_wb_we = 1'b0;
    #1;
    check("t2_head_addr", ow_gp_write_addr, 5'd10);
    check("t2_head_data", ow_gp_write_data, 32'hA0);
    check("t2_stall_hold", ow_wb_stall, 1'b1);
    check("t2_full_deq_ready", ow_mc_ready, 1'b0);
    step(); #1;
    check("t2_second_addr", ow_gp_write_addr, 5'd11);
    check("t2_second_data", ow_gp_write_data, 32'hB0);
    check("t2_stall_clear", ow_wb_stall, 1'b0);
    check("t2_count_2to1", ow_fifo_count, 1);
    check("t2_ready_back", ow_mc_ready, 1'b1);
    step(); #1;
    check("t2_drained", ow_fifo_count, 0);

    // WAW: queued r5 killed by a younger WB write to r5
    iw_mc_valid = 1'b1; iw_mc_addr = 5'd5; iw_mc_data = 32'hAAAA;
    step();
    iw_mc_valid = 1'b0;
    iw_wb_we = 1'b1; iw_wb_addr = 5'd5; iw_wb_data = 32'hBBBB;
    #1;
    check("t3_mask_set", ow_pending_mask[5], 1'b1);
    check("t3_wb_data", ow_gp_write_data, 32'hBBBB);
    step();
    iw_wb_we = 1'b0;
    #1;
    check("t3_mask_clear", ow_pending_mask[5], 1'b0);
    check("t3_killed_en", ow_gp_write_enable, 1'b0);
    check("t3_count", ow_fifo_count, 1);
    step(); #1;
    check("t3_drained", ow_fifo_count, 0);
    check("t3_no_stale", aaaa_written, 1'b0);

    // Same cycle WB r7 and MC enqueue r7: new entry survives
    iw_wb_we = 1'b1; iw_wb_addr = 5'd7; iw_wb_data = 32'h7777;
    iw_mc_valid = 1'b1; iw_mc_addr = 5'd7; iw_mc_data = 32'h7070;
    step();
    iw_wb_we = 1'b0; iw_mc_valid = 1'b0;
    #1;
    check("t4_mask7", ow_pending_mask[7], 1'b1);
    check("t4_en", ow_gp_write_enable, 1'b1);
    check("t4_data", ow_gp_write_data, 32'h7070);
    step();

    // Mixed traffic pattern, checked by the model
    for (int i = 0; i < 40; i++) begin
      iw_wb_we    = (i % 3) != 0;
      iw_wb_addr  = 5'(i % 6);
      iw_wb_data  = 32'(32'h5000 + i);
      iw_mc_valid = (i % 2) == 0;
      iw_mc_addr  = 5'((i * 5) % 8);
      iw_mc_data  = 32'(32'h9000 + i);
      step();
    end
    iw_wb_we = 1'b0; iw_mc_valid = 1'b0;
    repeat (3) step();

    // Async reset with two entries queued
    iw_wb_we = 1'b1; iw_wb_addr = 5'd1; iw_wb_data = 32'h1;
    iw_mc_valid = 1'b1; iw_mc_addr = 5'd12; iw_mc_data = 32'hC;
    step();
    iw_mc_addr = 5'd13; iw_mc_data = 32'hD;
    step();
    iw_mc_valid = 1'b0;
    #1; check("t6_count2", ow_fifo_count, 2);
    iw_rst = 1'b1;
    #1;
    check("t6_en0", ow_gp_write_enable, 1'b0);
    check("t6_ready0", ow_mc_ready, 1'b0);
    check("t6_count0", ow_fifo_count, 0);
    check("t6_mask0", ow_pending_mask, 0);
    step(); step();
    iw_rst = 1'b0; iw_wb_we = 1'b0;
    #1;
    check("t6_after_count", ow_fifo_count, 0);
    check("t6_after_ready", ow_mc_ready, 1'b1);
    check("t6_after_en", ow_gp_write_enable, 1'b0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
